// File: rtl/line_follow_pkg.sv
// line_follow_pkg: mode/state/side encodings and the road-pattern map for line_follow_ctrl.
package line_follow_pkg;
  localparam logic [1:0] MODE_STOP = 2'd0, MODE_FORWARD = 2'd1, MODE_LEFT = 2'd2, MODE_RIGHT = 2'd3;
  typedef enum logic [1:0] {IDLE, FOLLOW, SEARCH, HALT} state_t;
  typedef enum logic {SIDE_L, SIDE_R} side_t;
  function automatic logic [1:0] map_mode(input logic [2:0] f, input logic [1:0] cur);
    return (f == 3'b010 || f == 3'b111) ? MODE_FORWARD :
           (f == 3'b110 || f == 3'b100) ? MODE_LEFT :
           (f == 3'b011 || f == 3'b001) ? MODE_RIGHT :
           (f == 3'b101) ? cur : MODE_STOP;
  endfunction
endpackage

// File: rtl/road_debounce.sv
// road_debounce: accepts a 3-bit road pattern once it has been seen on DEBOUNCE consecutive edges.
module road_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] sample,
  output logic [2:0] filt
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE);
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0] prev;
  always_comb cnt_d = sample != prev ? CW'(1) : cnt == CMAX ? cnt : cnt + CW'(1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= 3'b000;
      cnt  <= '0;
      filt <= 3'b000;
    end else begin
      prev <= sample;
      cnt  <= cnt_d;
      if (cnt_d == CMAX) filt <= sample;
    end
  end
endmodule

// File: rtl/line_follow_ctrl.sv
// line_follow_ctrl: debounced line-follow steering FSM with bounded search on line loss.
// Optional LINE_FOLLOW_STOP_MARK_EN: an accepted 111 pattern while following halts the robot.
module line_follow_ctrl
  import line_follow_pkg::*;
#(
  parameter int DEBOUNCE     = 4,
  parameter int LOST_TIMEOUT = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] detect_road,
  output logic [1:0] mode,
  output logic       lost,
  output logic       halted
);
`ifdef LINE_FOLLOW_STOP_MARK_EN
  localparam bit STOP_MARK = 1'b1;
`else
  localparam bit STOP_MARK = 1'b0;
`endif
  localparam int TW = $clog2(LOST_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(LOST_TIMEOUT - 1);
  state_t state, nxt;
  side_t last_side, side_d;
  logic [1:0] mode_d;
  logic [2:0] filt;
  logic [TW-1:0] timer, timer_d;
  road_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
    .clk(clk), .reset(reset), .sample(detect_road), .filt(filt)
  );
  // Outputs are registered from the next state so they change on the transition edge.
  always_comb begin
    nxt = state;
    mode_d = mode;
    side_d = last_side;
    if (!enable) begin
      nxt = IDLE;
      mode_d = MODE_STOP;
    end else if (state == IDLE) begin
      nxt = FOLLOW;
      mode_d = MODE_STOP;
    end else if (state == HALT) begin
      mode_d = MODE_STOP;
    end else if (filt == 3'b000) begin
      nxt = (state == SEARCH && timer == T_LAST) ? HALT : SEARCH;
      mode_d = nxt == HALT ? MODE_STOP : last_side == SIDE_L ? MODE_LEFT : MODE_RIGHT;
    end else if (STOP_MARK && state == FOLLOW && filt == 3'b111) begin
      nxt = HALT;
      mode_d = MODE_STOP;
    end else begin
      nxt = FOLLOW;
      mode_d = map_mode(filt, mode);
      side_d = (filt == 3'b100 || filt == 3'b110) ? SIDE_L :
               (filt == 3'b001 || filt == 3'b011) ? SIDE_R : last_side;
    end
  end
  always_comb timer_d = (state == SEARCH && nxt == SEARCH) ? timer + TW'(timer != T_LAST) : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mode      <= MODE_STOP;
      lost      <= 1'b0;
      halted    <= 1'b0;
      last_side <= SIDE_L;
      timer     <= '0;
    end else begin
      state     <= nxt;
      mode      <= mode_d;
      lost      <= nxt == SEARCH;
      halted    <= nxt == HALT;
      last_side <= side_d;
      timer     <= timer_d;
    end
  end
endmodule

// File: tb/tb_line_follow_ctrl.sv
// tb_line_follow_ctrl: table-driven and directed checks of line_follow_ctrl (DEBOUNCE=4, LOST_TIMEOUT=10).
module tb_line_follow_ctrl;
  logic clk = 1'b0, reset = 1'b0, enable = 1'b0;
  logic [2:0] detect_road = 3'b000;
  logic [1:0] mode;
  logic lost, halted;
  int total = 0, bad = 0;
  typedef struct {
    logic       en;
    logic [2:0] d;
    logic [1:0] m;
    logic       l;
    logic       h;
  } vec_t;
  vec_t tbl[$];
  line_follow_ctrl #(.DEBOUNCE(4), .LOST_TIMEOUT(10)) dut (
    .clk(clk), .reset(reset), .enable(enable), .detect_road(detect_road),
    .mode(mode), .lost(lost), .halted(halted)
  );
  always #5 clk = ~clk;
  task automatic add(input int n, input logic e, input logic [2:0] d, input logic [1:0] m, input logic l, input logic h);
    repeat (n) tbl.push_back('{e, d, m, l, h});
  endtask
  task automatic tick(input logic e, input logic [2:0] d, input int n);
    repeat (n) begin
      enable = e;
      detect_road = d;
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string nm, input logic [1:0] m, input logic l, input logic h);
    total++;
    if ({mode, lost, halted} !== {m, l, h}) begin
      bad++;
      $display("FAIL %s: got mode=%0d lost=%0d halted=%0d, want mode=%0d lost=%0d halted=%0d",
               nm, mode, lost, halted, m, l, h);
    end
  endtask
  initial begin
    // latency to FORWARD, transient search, glitch rejection, LEFT/RIGHT, timeout to HALT
    add(1, 1, 3'b010, 0, 0, 0);
    add(3, 1, 3'b010, 2, 1, 0);
    add(2, 1, 3'b010, 1, 0, 0);
    add(3, 1, 3'b100, 1, 0, 0);
    add(2, 1, 3'b010, 1, 0, 0);
    add(4, 1, 3'b100, 1, 0, 0);
    add(1, 1, 3'b100, 2, 0, 0);
    add(4, 1, 3'b001, 2, 0, 0);
    add(1, 1, 3'b001, 3, 0, 0);
    add(4, 1, 3'b000, 3, 0, 0);
    add(10, 1, 3'b000, 3, 1, 0);
    add(2, 1, 3'b000, 0, 0, 1);
    add(1, 0, 3'b000, 0, 0, 0);
    #2 reset = 1'b1;
    #1 chk("reset_state", 0, 0, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    foreach (tbl[i]) begin
      tick(tbl[i].en, tbl[i].d, 1);
      chk($sformatf("row%0d", i + 1), tbl[i].m, tbl[i].l, tbl[i].h);
    end
    // reacquire during search at timer 5
    tick(1, 3'b000, 1);
    chk("idle_to_follow", 0, 0, 0);
    tick(1, 3'b000, 1);
    chk("search_right", 3, 1, 0);
    tick(1, 3'b000, 1);
    tick(1, 3'b010, 4);
    chk("pre_reacquire", 3, 1, 0);
    tick(1, 3'b010, 1);
    chk("reacquire", 1, 0, 0);
    // reacquire coincides with timeout
    tick(1, 3'b000, 4);
    chk("follow_before_loss", 1, 0, 0);
    tick(1, 3'b000, 1);
    chk("search_entry", 3, 1, 0);
    tick(1, 3'b000, 5);
    tick(1, 3'b010, 4);
    chk("search_at_last_tick", 3, 1, 0);
    tick(1, 3'b010, 1);
    chk("reacquire_beats_timeout", 1, 0, 0);
    // stop marker
    tick(1, 3'b111, 4);
    chk("pre_stop_mark", 1, 0, 0);
    tick(1, 3'b111, 1);
`ifdef LINE_FOLLOW_STOP_MARK_EN
    chk("stop_mark_halt", 0, 0, 1);
`else
    chk("all_black_forward", 1, 0, 0);
`endif
    tick(0, 3'b111, 1);
    chk("enable_low_idle", 0, 0, 0);
    // asynchronous reset in the middle of a search
    tick(0, 3'b000, 4);
    chk("idle_hold", 0, 0, 0);
    tick(1, 3'b000, 1);
    chk("idle_to_follow2", 0, 0, 0);
    tick(1, 3'b000, 1);
    chk("search_right2", 3, 1, 0);
    #2 reset = 1'b1;
    #1 chk("async_reset", 0, 0, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    tick(1, 3'b000, 1);
    chk("post_reset_follow", 0, 0, 0);
    tick(1, 3'b000, 1);
    chk("side_reset_left", 2, 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
